// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-stage types: micro-op descriptor, FIFO entry, grant source.
package wb_arbiter_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 is_store;
        logic                 is_load;
    } uop_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        uop_t            uop;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_LSU  = 2'd1,
        GRANT_ALU  = 2'd2
    } grant_e;

    // Stores and writes to x0 retire without touching the register file.
    function automatic logic writes_rf(input uop_t u);
        return !u.is_store && (u.rd != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count and empty/full flags.
// Read data is the current head, available combinationally.
module wb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign rdata  = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Overflow is an upstream protocol error; the FIFO makes no attempt to recover.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("wb_fifo: push while full without pop");

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges buffered LSU completions and handshaked ALU
// results onto the single register-file write port, with ALU anti-starvation.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned LSU_Q_DEPTH = 4,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lsu_valid,
    input  logic [XLEN-1:0]      i_lsu_data,
    input  uop_t                 i_lsu_uop,
    output logic                 o_lsu_hold,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [XLEN-1:0]      i_alu_result,
    input  uop_t                 i_alu_uop,
    output logic                 o_rf_we,
    output logic [REG_IDX_W-1:0] o_rf_waddr,
    output logic [XLEN-1:0]      o_rf_wdata,
    output logic                 o_fwd_valid,
    output logic [REG_IDX_W-1:0] o_fwd_rd,
    output logic [XLEN-1:0]      o_fwd_data,
    output logic                 o_retire_valid,
    output uop_t                 o_retire_uop
);

    localparam int unsigned CNT_W = $clog2(LSU_Q_DEPTH) + 1;
    localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wb_entry_t        q_in;
    wb_entry_t        q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    logic             q_full;
    logic             q_pop;

    logic [STV_W-1:0] starve_cnt;
    logic             starve_at_max;
    logic             force_alu;
    grant_e           grant;
    logic [XLEN-1:0]  sel_data;
    uop_t             sel_uop;

    assign q_in = '{data: i_lsu_data, uop: i_lsu_uop};

    wb_fifo #(
        .WIDTH($bits(wb_entry_t)),
        .DEPTH(LSU_Q_DEPTH)
    ) u_lsu_q (
        .clk   (clk),
        .rst   (rst),
        .push  (i_lsu_valid),
        .wdata (q_in),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign o_lsu_hold    = (q_count >= CNT_W'(LSU_Q_DEPTH - 1));
    assign starve_at_max = (starve_cnt == STV_W'(STARVE_MAX));
    // A completely full queue must drain first, or the next LSU pulse would overflow.
    assign force_alu     = i_alu_valid && starve_at_max && !q_full;

    // One grant per cycle: queued LSU results first, unless the ALU has starved.
    always_comb begin
        grant = GRANT_NONE;
        if (rst) begin
            grant = GRANT_NONE;
        end else if (!q_empty && !force_alu) begin
            grant = GRANT_LSU;
        end else if (force_alu || (i_alu_valid && q_empty)) begin
            grant = GRANT_ALU;
        end
    end

    assign o_alu_ready = (grant == GRANT_ALU);
    assign q_pop       = (grant == GRANT_LSU);

    // Select the winning source's result and descriptor.
    always_comb begin
        sel_data = '0;
        sel_uop  = '0;
        case (grant)
            GRANT_LSU: begin
                sel_data = q_head.data;
                sel_uop  = q_head.uop;
            end
            GRANT_ALU: begin
                sel_data = i_alu_result;
                sel_uop  = i_alu_uop;
            end
            default: ;
        endcase
    end

    // Count consecutive cycles a valid ALU result is refused, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_alu_valid && !o_alu_ready) begin
            if (!starve_at_max) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Register the granted write and retire; everything clears when idle.
    always_ff @(posedge clk) begin
        if (rst || grant == GRANT_NONE) begin
            o_rf_we        <= 1'b0;
            o_rf_waddr     <= '0;
            o_rf_wdata     <= '0;
            o_retire_valid <= 1'b0;
            o_retire_uop   <= '0;
        end else begin
            o_rf_we        <= writes_rf(sel_uop);
            o_rf_waddr     <= sel_uop.rd;
            o_rf_wdata     <= sel_data;
            o_retire_valid <= 1'b1;
            o_retire_uop   <= sel_uop;
        end
    end

    assign o_fwd_valid = o_rf_we;
    assign o_fwd_rd    = o_rf_waddr;
    assign o_fwd_data  = o_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic        clk;
    logic        rst;
    logic        i_lsu_valid;
    logic [31:0] i_lsu_data;
    uop_t        i_lsu_uop;
    logic        o_lsu_hold;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [31:0] i_alu_result;
    uop_t        i_alu_uop;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_rd;
    logic [31:0] o_fwd_data;
    logic        o_retire_valid;
    uop_t        o_retire_uop;

    wb_arbiter #(.LSU_Q_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_lsu_valid(i_lsu_valid), .i_lsu_data(i_lsu_data), .i_lsu_uop(i_lsu_uop),
        .o_lsu_hold(o_lsu_hold),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_result(i_alu_result), .i_alu_uop(i_alu_uop),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data),
        .o_retire_valid(o_retire_valid), .o_retire_uop(o_retire_uop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue of pending LSU results and a starvation counter.
    typedef struct {
        logic [31:0] data;
        uop_t        uop;
    } ent_t;

    ent_t        m_q[$];
    int          m_starve = 0;
    int          m_grant  = 0;  // 0 none, 1 LSU, 2 ALU
    logic        exp_ready, exp_hold, exp_we, exp_ret;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    uop_t        exp_uop;
    logic [31:0] obs_lsu[$];

    task automatic model_eval();
        int  cnt;
        bit  force_alu;
        cnt       = m_q.size();
        force_alu = i_alu_valid && (m_starve == SMAX) && (cnt < DEPTH);
        if (rst)                                  m_grant = 0;
        else if (cnt > 0 && !force_alu)           m_grant = 1;
        else if (force_alu || (i_alu_valid && cnt == 0)) m_grant = 2;
        else                                      m_grant = 0;
        exp_ready = (m_grant == 2);
        exp_hold  = (cnt >= DEPTH - 1);
    endtask

    task automatic model_clock();
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_starve = 0;
            exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_ret = 0; exp_uop = '0;
            return;
        end
        e.data = '0;
        e.uop  = '0;
        if (m_grant == 1) e = m_q.pop_front();
        else if (m_grant == 2) begin
            e.data = i_alu_result;
            e.uop  = i_alu_uop;
        end
        exp_ret   = (m_grant != 0);
        exp_uop   = exp_ret ? e.uop : '0;
        exp_waddr = exp_ret ? e.uop.rd : '0;
        exp_wdata = exp_ret ? e.data : '0;
        exp_we    = exp_ret && !e.uop.is_store && (e.uop.rd != 0);
        if (i_lsu_valid) m_q.push_back('{data: i_lsu_data, uop: i_lsu_uop});
        if (i_alu_valid && !exp_ready) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
    endtask

    // Advance one clock, update the model, sample 1 time unit after the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clock();
        #1;
        cyc++;
        if (o_retire_valid && o_retire_uop.is_load) obs_lsu.push_back(o_rf_wdata);
    endtask

    task automatic set_lsu(input bit v, input logic [31:0] d, input logic [4:0] rd, input bit st);
        i_lsu_valid = v;
        i_lsu_data  = d;
        i_lsu_uop   = '{rd: rd, is_store: st, is_load: !st};
    endtask

    task automatic set_alu(input bit v, input logic [31:0] d, input logic [4:0] rd);
        i_alu_valid  = v;
        i_alu_result = d;
        i_alu_uop    = '{rd: rd, is_store: 1'b0, is_load: 1'b0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_lsu(0, '0, '0, 0);
        set_alu(1, 32'h1111_1111, 5'd1);
        #1;
        checks++; if (o_alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_alu_ready); end
        tick(); tick();
        checks++; if (o_alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready2 got %b want 0", o_alu_ready); end
        checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_rf_we); end
        checks++; if (o_rf_waddr !== 5'd0 || o_rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wr got %h/%h want 0/0", o_rf_waddr, o_rf_wdata); end
        checks++; if (o_fwd_valid !== 1'b0 || o_fwd_rd !== 5'd0 || o_fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd got %b/%h/%h want 0", o_fwd_valid, o_fwd_rd, o_fwd_data); end
        checks++; if (o_retire_valid !== 1'b0 || o_retire_uop !== '0) begin errors++; $display("FAIL reset_retire got %b/%h want 0/0", o_retire_valid, o_retire_uop); end
        checks++; if (o_lsu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", o_lsu_hold); end
        set_alu(0, '0, '0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsu_single();
        obs_lsu.delete();
        tick(); tick();
        set_lsu(1, 32'hDEAD_BEEF, 5'd5, 0);
        #1;
        checks++; if (o_lsu_hold !== 1'b0) begin errors++; $display("FAIL lsu1_hold0 got %b want 0", o_lsu_hold); end
        tick();
        set_lsu(0, '0, '0, 0);
        checks++; if (o_rf_we !== 1'b0 || o_retire_valid !== 1'b0) begin errors++; $display("FAIL lsu1_early got we=%b ret=%b want 0/0", o_rf_we, o_retire_valid); end
        checks++; if (o_lsu_hold !== 1'b0) begin errors++; $display("FAIL lsu1_hold1 got %b want 0", o_lsu_hold); end
        tick();
        checks++; if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd5 || o_rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lsu1_write got %b/%0d/%h want 1/5/deadbeef", o_rf_we, o_rf_waddr, o_rf_wdata); end
        checks++; if (o_fwd_valid !== 1'b1 || o_fwd_rd !== 5'd5 || o_fwd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lsu1_fwd got %b/%0d/%h want 1/5/deadbeef", o_fwd_valid, o_fwd_rd, o_fwd_data); end
        checks++; if (o_retire_valid !== 1'b1 || o_retire_uop.rd !== 5'd5) begin errors++; $display("FAIL lsu1_retire got %b rd=%0d want 1 rd=5", o_retire_valid, o_retire_uop.rd); end
        checks++; if (o_lsu_hold !== 1'b0) begin errors++; $display("FAIL lsu1_hold2 got %b want 0", o_lsu_hold); end
        tick();
        checks++; if (o_retire_valid !== 1'b0 || o_rf_we !== 1'b0) begin errors++; $display("FAIL lsu1_after got ret=%b we=%b want 0/0", o_retire_valid, o_rf_we); end
    endtask

    task automatic test_alu();
        set_alu(1, 32'h12, 5'd3);
        #1;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", o_alu_ready); end
        tick();
        set_alu(0, '0, '0);
        checks++; if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd3 || o_rf_wdata !== 32'h12) begin errors++; $display("FAIL alu_write got %b/%0d/%h want 1/3/12", o_rf_we, o_rf_waddr, o_rf_wdata); end
        set_alu(1, 32'h55, 5'd0);
        #1;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL alu_x0_ready got %b want 1", o_alu_ready); end
        tick();
        set_alu(0, '0, '0);
        checks++; if (o_rf_we !== 1'b0 || o_fwd_valid !== 1'b0 || o_retire_valid !== 1'b1) begin errors++; $display("FAIL alu_x0 got we=%b fwd=%b ret=%b want 0/0/1", o_rf_we, o_fwd_valid, o_retire_valid); end
        tick();
    endtask

    task automatic test_store();
        set_lsu(1, 32'h0000_CAFE, 5'd7, 1);
        tick();
        set_lsu(0, '0, '0, 0);
        tick();
        checks++; if (o_rf_we !== 1'b0 || o_retire_valid !== 1'b1 || o_retire_uop.is_store !== 1'b1) begin errors++; $display("FAIL store got we=%b ret=%b st=%b want 0/1/1", o_rf_we, o_retire_valid, o_retire_uop.is_store); end
        tick();
    endtask

    task automatic test_back_to_back();
        int  alu_sent = 1;
        int  alu_ret  = 0;
        int  lsu_at   = -1;
        bit  rdy;
        obs_lsu.delete();
        set_alu(1, 32'hA000_0014, 5'd20);
        for (int c = 0; c < 30; c++) begin
            if (c < 4) set_lsu(1, 32'h100 + c, 5'(c + 1), 0);
            else       set_lsu(0, '0, '0, 0);
            #1;
            model_eval();
            checks++; if (o_lsu_hold !== exp_hold) begin errors++; $display("FAIL b2b_hold cyc %0d got %b want %b", cyc, o_lsu_hold, exp_hold); end
            checks++; if (o_alu_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", cyc, o_alu_ready, exp_ready); end
            rdy = exp_ready;
            tick();
            if (o_retire_valid && !o_retire_uop.is_load && !o_retire_uop.is_store) begin
                alu_ret++;
                if (alu_ret == 2) lsu_at = obs_lsu.size();
            end
            if (rdy) begin
                if (alu_sent < 3) begin
                    set_alu(1, 32'hA000_0014 + alu_sent, 5'(20 + alu_sent));
                    alu_sent++;
                end else set_alu(0, '0, '0);
            end
        end
        checks++; if (obs_lsu.size() != 4) begin errors++; $display("FAIL b2b_lsu_count got %0d want 4", obs_lsu.size()); end
        for (int i = 0; i < obs_lsu.size() && i < 4; i++) begin
            checks++; if (obs_lsu[i] !== 32'h100 + i) begin errors++; $display("FAIL b2b_order idx %0d got %h want %h", i, obs_lsu[i], 32'h100 + i); end
        end
        checks++; if (alu_ret != 3) begin errors++; $display("FAIL b2b_alu_count got %0d want 3", alu_ret); end
        checks++; if (lsu_at != 3) begin errors++; $display("FAIL b2b_forced_after got %0d lsu retires want 3", lsu_at); end
    endtask

    task automatic test_push_pop();
        int seq = 0;
        bit rdy;
        bit filled = 0;
        obs_lsu.delete();
        set_alu(1, 32'hB000_0000, 5'd11);
        for (int c = 0; c < 40; c++) begin
            set_lsu(1, 32'h5000_0000 + seq, 5'((seq % 31) + 1), 0);
            #1;
            model_eval();
            rdy = exp_ready;
            tick();
            seq++;
            if (rdy) begin
                if (m_q.size() >= 2) begin
                    set_alu(0, '0, '0);
                    filled = 1;
                    break;
                end
                set_alu(1, 32'hB000_0000 + c, 5'd11);
            end
        end
        checks++; if (!filled) begin errors++; $display("FAIL pp_fill timeout got filled=0 want 1"); end
        for (int c = 0; c < 6; c++) begin
            set_lsu(1, 32'h5000_0000 + seq, 5'((seq % 31) + 1), 0);
            #1;
            checks++; if (o_lsu_hold !== 1'b0) begin errors++; $display("FAIL pp_hold cyc %0d got %b want 0", cyc, o_lsu_hold); end
            tick();
            seq++;
            checks++; if (o_retire_valid !== 1'b1 || o_retire_uop.is_load !== 1'b1) begin errors++; $display("FAIL pp_pop cyc %0d got ret=%b ld=%b want 1/1", cyc, o_retire_valid, o_retire_uop.is_load); end
        end
        set_lsu(0, '0, '0, 0);
        for (int c = 0; c < 5; c++) tick();
        checks++; if (obs_lsu.size() != seq) begin errors++; $display("FAIL pp_count got %0d want %0d", obs_lsu.size(), seq); end
        for (int i = 0; i < obs_lsu.size() && i < seq; i++) begin
            checks++; if (obs_lsu[i] !== 32'h5000_0000 + i) begin errors++; $display("FAIL pp_order idx %0d got %h want %h", i, obs_lsu[i], 32'h5000_0000 + i); end
        end
    endtask

    task automatic test_reset_mid();
        int seq = 0;
        bit rdy;
        set_alu(1, 32'hC000_0000, 5'd12);
        for (int c = 0; c < 60; c++) begin
            set_lsu(1, 32'h7000_0000 + seq, 5'd13, 0);
            #1;
            model_eval();
            rdy = exp_ready;
            tick();
            seq++;
            if (rdy) set_alu(1, 32'hC000_0000 + c, 5'd12);
            if (m_q.size() >= 3) break;
        end
        set_lsu(0, '0, '0, 0);
        checks++; if (o_lsu_hold !== 1'b1) begin errors++; $display("FAIL rmid_hold_full got %b want 1", o_lsu_hold); end
        rst = 1'b1;
        set_alu(0, '0, '0);
        tick();
        rst = 1'b0;
        checks++; if (o_rf_we !== 1'b0 || o_retire_valid !== 1'b0 || o_lsu_hold !== 1'b0) begin errors++; $display("FAIL rmid_after got we=%b ret=%b hold=%b want 0/0/0", o_rf_we, o_retire_valid, o_lsu_hold); end
        obs_lsu.delete();
        tick();
        checks++; if (o_retire_valid !== 1'b0) begin errors++; $display("FAIL rmid_discard got ret=%b want 0", o_retire_valid); end
        set_lsu(1, 32'h0BAD_F00D, 5'd9, 0);
        tick();
        set_lsu(0, '0, '0, 0);
        checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL rmid_early got %b want 0", o_rf_we); end
        tick();
        checks++; if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd9 || o_rf_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rmid_write got %b/%0d/%h want 1/9/0badf00d", o_rf_we, o_rf_waddr, o_rf_wdata); end
        tick(); tick();
        checks++; if (obs_lsu.size() != 1) begin errors++; $display("FAIL rmid_count got %0d want 1", obs_lsu.size()); end
    endtask

    task automatic test_random();
        bit rdy;
        uop_t u;
        for (int c = 0; c < 400; c++) begin
            if (!i_alu_valid && $urandom_range(0, 2) == 0) begin
                set_alu(1, $urandom, 5'($urandom_range(0, 31)));
            end
            model_eval();
            if (!exp_hold && $urandom_range(0, 1) == 1) begin
                set_lsu(1, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
            end else set_lsu(0, '0, '0, 0);
            #1;
            model_eval();
            checks++; if (o_alu_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, o_alu_ready, exp_ready); end
            checks++; if (o_lsu_hold !== exp_hold) begin errors++; $display("FAIL rnd_hold cyc %0d got %b want %b", cyc, o_lsu_hold, exp_hold); end
            rdy = exp_ready;
            tick();
            if (rdy) set_alu(0, '0, '0);
            checks++; if (o_retire_valid !== exp_ret) begin errors++; $display("FAIL rnd_ret cyc %0d got %b want %b", cyc, o_retire_valid, exp_ret); end
            checks++; if (o_rf_we !== exp_we || o_fwd_valid !== exp_we) begin errors++; $display("FAIL rnd_we cyc %0d got %b/%b want %b", cyc, o_rf_we, o_fwd_valid, exp_we); end
            if (exp_ret) begin
                u = o_retire_uop;
                checks++; if (u !== exp_uop) begin errors++; $display("FAIL rnd_uop cyc %0d got %h want %h", cyc, u, exp_uop); end
                checks++; if (o_rf_waddr !== exp_waddr || o_rf_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wr cyc %0d got %0d/%h want %0d/%h", cyc, o_rf_waddr, o_rf_wdata, exp_waddr, exp_wdata); end
                checks++; if (o_fwd_rd !== exp_waddr || o_fwd_data !== exp_wdata) begin errors++; $display("FAIL rnd_fwd cyc %0d got %0d/%h want %0d/%h", cyc, o_fwd_rd, o_fwd_data, exp_waddr, exp_wdata); end
            end
        end
        set_lsu(0, '0, '0, 0);
        set_alu(0, '0, '0);
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_lsu(0, '0, '0, 0);
        set_alu(0, '0, '0);
        exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_ret = 0; exp_uop = '0;
        test_reset();
        test_lsu_single();
        test_alu();
        test_store();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
